// File: rtl/cal_sweep_ctrl_if.sv
// Calibration request/complete handshake between cal_sweep_ctrl (master) and the
// calibration sequencer (slave): cal_b request, cal_done level, comp_res sample.
interface cal_sweep_ctrl_if;
    logic cal_b;
    logic cal_done;
    logic comp_res;

    modport master (
        output cal_b,
        input  cal_done,
        input  comp_res
    );

    modport slave (
        input  cal_b,
        output cal_done,
        output comp_res
    );
endinterface

// File: rtl/cal_sweep_ctrl.sv
// Column calibration sweep: NUM_REP majority-voted handshake passes per column.
// Optional handshake watchdog is built only when CAL_TIMEOUT_EN is defined.
module cal_sweep_ctrl #(
    parameter int NUM_COL     = 16,
    parameter int NUM_REP     = 3,
    parameter int TIMEOUT_CYC = 64,
    localparam int COL_W      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    cal_sweep_ctrl_if.master    cal,
    output logic [COL_W-1:0]    col_addr,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [NUM_COL-1:0]  result
);

    localparam int REP_W = $clog2(NUM_REP + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(NUM_REP - 1);
    localparam logic [REP_W:0]   REP_LIM  = (REP_W + 1)'(NUM_REP);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COL - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL,
        DONE
    } state_t;

    state_t           state;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] ones;
    logic             vote;

    // Strict majority: 2*ones > NUM_REP, so an even-count tie resolves to 0.
    assign vote = {ones, 1'b0} > REP_LIM;

`ifdef CAL_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] timer;
    logic             err_flag;
    logic             expired;

    assign expired = (timer == TMR_LAST);
    assign err     = err_flag;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cal.cal_b <= 1'b0;
            col_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            rep_cnt   <= '0;
            ones      <= '0;
`ifdef CAL_TIMEOUT_EN
            timer     <= '0;
            err_flag  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Holding off while cal_done is still high keeps the level handshake in order.
                    if (start && !cal.cal_done) begin
                        result    <= '0;
                        col_addr  <= '0;
                        rep_cnt   <= '0;
                        ones      <= '0;
                        cal.cal_b <= 1'b1;
                        busy      <= 1'b1;
                        state     <= REQ;
`ifdef CAL_TIMEOUT_EN
                        timer     <= '0;
                        err_flag  <= 1'b0;
`endif
                    end
                end

                REQ: begin
                    if (abort) begin
                        cal.cal_b <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef CAL_TIMEOUT_EN
                        timer     <= '0;
`endif
                    end else if (cal.cal_done) begin
                        ones      <= ones + REP_W'(cal.comp_res);
                        cal.cal_b <= 1'b0;
                        state     <= REL;
`ifdef CAL_TIMEOUT_EN
                        timer     <= '0;
`endif
                    end
`ifdef CAL_TIMEOUT_EN
                    else if (expired) begin
                        err_flag  <= 1'b1;
                        cal.cal_b <= 1'b0;
                        done      <= 1'b1;
                        timer     <= '0;
                        state     <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end

                REL: begin
                    if (abort) begin
                        cal.cal_b <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef CAL_TIMEOUT_EN
                        timer     <= '0;
`endif
                    end else if (!cal.cal_done) begin
`ifdef CAL_TIMEOUT_EN
                        timer <= '0;
`endif
                        if (rep_cnt < REP_LAST) begin
                            rep_cnt   <= rep_cnt + 1'b1;
                            cal.cal_b <= 1'b1;
                            state     <= REQ;
                        end else begin
                            // ones already includes the pass that just completed.
                            result[col_addr] <= vote;
                            ones             <= '0;
                            rep_cnt          <= '0;
                            if (col_addr == COL_LAST) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                col_addr  <= col_addr + 1'b1;
                                cal.cal_b <= 1'b1;
                                state     <= REQ;
                            end
                        end
                    end
`ifdef CAL_TIMEOUT_EN
                    else if (expired) begin
                        err_flag  <= 1'b1;
                        cal.cal_b <= 1'b0;
                        done      <= 1'b1;
                        timer     <= '0;
                        state     <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    cal.cal_b <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cal_sweep_ctrl.sv
// Scoreboard bench for cal_sweep_ctrl: a behavioural sequencer answers the handshake
// from a per-pass vote table, and a monitor checks each done pulse against queued results.
module tb_cal_sweep_ctrl;

    localparam int NC = 4;
    localparam int NR = 3;
    localparam int TO = 8;
`ifdef CAL_TIMEOUT_EN
    localparam int LONG_DLY = 5;
`else
    localparam int LONG_DLY = 12;
`endif

    typedef struct {
        logic [NC-1:0] res;
        logic          err;
        int            passes;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    col_addr;
    logic          busy;
    logic          done;
    logic          err;
    logic [NC-1:0] result;

    cal_sweep_ctrl_if cal ();

    cal_sweep_ctrl #(
        .NUM_COL    (NC),
        .NUM_REP    (NR),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .cal     (cal),
        .col_addr(col_addr),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int   votes [NC*NR];
    exp_t sb [$];
    int   seq_mode = 0;
    int   seq_lo = 0;
    int   seq_hi = 3;
    int   seq_pass = 0;
    int   seq_cnt = 0;
    int   rise_cnt = 0;
    int   done_cnt = 0;
    int   rise_cyc = 0;
    int   done_cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: strict majority of the first ncols columns' pass votes.
    function automatic logic [NC-1:0] refResult(input int ncols);
        logic [NC-1:0] r;
        r = '0;
        for (int c = 0; c < ncols; c++) begin
            int n;
            n = 0;
            for (int p = 0; p < NR; p++) n += votes[c*NR + p];
            r[c] = (2 * n > NR);
        end
        return r;
    endfunction

    // Sequencer model: mode 0 answers after a random delay, 1 stays silent, 2 holds cal_done high.
    initial begin
        cal.cal_done = 1'b0;
        cal.comp_res = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (seq_mode == 2) begin
                cal.cal_done = 1'b1;
            end else if (seq_mode == 1) begin
                cal.cal_done = 1'b0;
            end else if (!cal.cal_done) begin
                if (!cal.cal_b) begin
                    seq_cnt = $urandom_range(seq_hi, seq_lo);
                end else if (seq_cnt == 0) begin
                    cal.cal_done = 1'b1;
                    cal.comp_res = (seq_pass < NC*NR) ? (votes[seq_pass] != 0) : 1'b0;
                    seq_pass++;
                    seq_cnt = $urandom_range(seq_hi, seq_lo);
                end else begin
                    seq_cnt--;
                end
            end else if (!cal.cal_b) begin
                if (seq_cnt == 0) begin
                    cal.cal_done = 1'b0;
                    cal.comp_res = 1'($urandom);
                    seq_cnt = $urandom_range(seq_hi, seq_lo);
                end else begin
                    seq_cnt--;
                end
            end
        end
    end

    // Monitor: handshake ordering, column per request, and scoreboard pop on done.
    initial begin
        logic prev_cb;
        logic prev_done;
        exp_t e;
        prev_cb = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cal.cal_b && !prev_cb) begin
                checkOutput("cal_b_rise_vs_cal_done", 32'(cal.cal_done), 32'd0);
                checkOutput("col_addr_at_request", 32'(col_addr), 32'(rise_cnt / NR));
                rise_cnt++;
                rise_cyc = cyc;
            end
            if (done) begin
                checkOutput("done_width", 32'(prev_done), 32'd0);
                done_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no pulse");
                end else begin
                    e = sb.pop_front();
                    checkOutput("result", 32'(result), 32'(e.res));
                    checkOutput("err", 32'(err), 32'(e.err));
                    checkOutput("request_count", 32'(rise_cnt), 32'(e.passes));
                    checkOutput("busy_in_done", 32'(busy), 32'd1);
                end
                done_cnt++;
            end
            prev_cb = cal.cal_b;
            prev_done = done;
        end
    end

    task automatic stepDrive();
        @(posedge clk);
        #3;
    endtask

    task automatic stepSample();
        @(posedge clk);
        #1;
    endtask

    // Returns at a drive point (+3) once the DUT and sequencer are both idle.
    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            stepSample();
            if (!cal.cal_done && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("idle_wait", 32'(ok), 32'd1);
        #2;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        stepDrive();
        start = 1'b0;
    endtask

    // Full sweep with stray starts while busy; optionally abort together with the start.
    task automatic applyStimulus(input int lo, input int hi, input bit rand_votes, input bit with_abort);
        exp_t e;
        int   n0;
        bit   got;
        waitIdle();
        if (rand_votes) for (int i = 0; i < NC*NR; i++) votes[i] = $urandom_range(1, 0);
        seq_lo = lo;
        seq_hi = hi;
        seq_pass = 0;
        rise_cnt = 0;
        e.res = refResult(NC);
        e.err = 1'b0;
        e.passes = NC * NR;
        sb.push_back(e);
        n0 = done_cnt;
        start = 1'b1;
        abort = with_abort;
        stepDrive();
        start = 1'b0;
        abort = 1'b0;
        got = 1'b0;
        for (int i = 0; i < NC*NR*2*(hi + 4) + 40; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt != n0) begin
                got = 1'b1;
                break;
            end
            #2;
            start = busy && ($urandom_range(7, 0) == 0);
        end
        #2;
        start = 1'b0;
        checkOutput("sweep_completes", 32'(got), 32'd1);
        stepSample();
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic applyAbort();
        bit found;
        waitIdle();
        for (int i = 0; i < NC*NR; i++) votes[i] = $urandom_range(1, 0);
        seq_lo = 2;
        seq_hi = 4;
        seq_pass = 0;
        rise_cnt = 0;
        pulseStart();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (col_addr == 2'd2 && cal.cal_b && !cal.cal_done) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("abort_reached_col2", 32'(found), 32'd1);
        #2;
        abort = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_cal_b", 32'(cal.cal_b), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_col_addr", 32'(col_addr), 32'd2);
        checkOutput("abort_result", 32'(result), 32'(refResult(2)));
        #2;
        abort = 1'b0;
        repeat (6) stepSample();
        checkOutput("abort_stays_idle", 32'(busy), 32'd0);
        #2;
    endtask

    task automatic applyReset();
        exp_t e;
        bit   found;
        waitIdle();
        for (int i = 0; i < NC*NR; i++) votes[i] = 1;
        seq_lo = 2;
        seq_hi = 4;
        seq_pass = 0;
        rise_cnt = 0;
        e.res = refResult(NC);
        e.err = 1'b0;
        e.passes = NC * NR;
        sb.push_back(e);
        pulseStart();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (busy && !cal.cal_b && cal.cal_done && rise_cnt >= 5) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reset_reached_rel", 32'(found), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_cal_b", 32'(cal.cal_b), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_col_addr", 32'(col_addr), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        sb.delete();
        repeat (2) stepDrive();
        rst = 1'b1;
    endtask

`ifdef CAL_TIMEOUT_EN
    task automatic applyTimeout();
        exp_t e;
        int   n0;
        bit   got;
        waitIdle();
        seq_mode = 1;
        rise_cnt = 0;
        e.res = '0;
        e.err = 1'b1;
        e.passes = 1;
        sb.push_back(e);
        n0 = done_cnt;
        pulseStart();
        got = 1'b0;
        for (int i = 0; i < 4*TO + 20; i++) begin
            stepSample();
            if (done_cnt != n0) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("timeout_done", 32'(got), 32'd1);
        checkOutput("timeout_latency", 32'(done_cyc - rise_cyc), 32'(TO));
        repeat (3) stepSample();
        checkOutput("timeout_err_sticky", 32'(err), 32'd1);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        checkOutput("timeout_cal_b", 32'(cal.cal_b), 32'd0);
        #2;
        seq_mode = 0;
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 50000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        repeat (3) stepDrive();
        rst = 1'b1;
        stepSample();
        checkOutput("reset_cal_b", 32'(cal.cal_b), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_col_addr", 32'(col_addr), 32'd0);

        $display("[TB] basic sweep, comp_res 1,1,0,1 per column");
        for (int c = 0; c < NC; c++)
            for (int p = 0; p < NR; p++) votes[c*NR + p] = (c == 2) ? 0 : 1;
        applyStimulus(LONG_DLY, LONG_DLY, 1'b0, 1'b0);

        $display("[TB] majority vote patterns");
        votes = '{1, 0, 1,  0, 0, 1,  1, 1, 0,  0, 1, 0};
        applyStimulus(0, 3, 1'b0, 1'b0);

        $display("[TB] start and abort together in IDLE");
        applyStimulus(0, 4, 1'b1, 1'b1);

        $display("[TB] start while cal_done high is dropped");
        waitIdle();
        seq_mode = 2;
        repeat (2) stepDrive();
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            stepSample();
            checkOutput("blocked_start_busy", 32'(busy), 32'd0);
            checkOutput("blocked_start_cal_b", 32'(cal.cal_b), 32'd0);
        end
        #2;
        seq_mode = 0;

        $display("[TB] abort in REQ at column 2");
        applyAbort();

`ifdef CAL_TIMEOUT_EN
        $display("[TB] handshake timeout");
        applyTimeout();
        applyStimulus(0, 4, 1'b1, 1'b0);
`endif

        $display("[TB] reset mid-REL");
        applyReset();
        applyStimulus(0, 4, 1'b1, 1'b0);

        $display("[TB] random sweeps");
        for (int k = 0; k < 4; k++) applyStimulus(0, 5, 1'b1, 1'b0);

        repeat (4) stepSample();
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
